// File: rtl/semaforo_multi.sv
`timescale 1ns/1ps
// semaforo_multi: N-way round-robin traffic-light controller with min/max green.
// Define SEMAFORO_PED_EN to compile in the pedestrian WALK phase (ped_req / ped_walk).
module semaforo_multi #(
    parameter int N_DIR         = 4,
    parameter int GREEN_CYCLES  = 4,
    parameter int MAX_GREEN     = 8,
    parameter int YELLOW_CYCLES = 2,
    parameter int ALLRED_CYCLES = 1,
    parameter int PED_CYCLES    = 3
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_DIR-1:0]         traffic,
`ifdef SEMAFORO_PED_EN
    input  logic                     ped_req,
    output logic                     ped_walk,
`endif
    output logic [2*N_DIR-1:0]       light,
    output logic [$clog2(N_DIR)-1:0] active_dir
);
    localparam int DW = $clog2(N_DIR);
    localparam int MA = (MAX_GREEN > GREEN_CYCLES) ? MAX_GREEN : GREEN_CYCLES;
    localparam int MB = (YELLOW_CYCLES > ALLRED_CYCLES) ? YELLOW_CYCLES : ALLRED_CYCLES;
    localparam int MC = (MA > MB) ? MA : MB;
    localparam int MP = (MC > PED_CYCLES) ? MC : PED_CYCLES;
    localparam int TW = $clog2(MP + 1);

`ifdef SEMAFORO_PED_EN
    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_WALK} state_t;
`else
    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED} state_t;
`endif

    state_t          state, state_nx;
    logic [TW-1:0]   timer;
    logic [DW-1:0]   next_dir, cand, idx;
    logic            ped_pending, other_demand, go_yellow;

    assign other_demand = (|(traffic & ~(N_DIR'(1) << active_dir))) | ped_pending;
    assign go_yellow = timer >= TW'(GREEN_CYCLES - 1) && other_demand &&
                       (!traffic[active_dir] || timer >= TW'(MAX_GREEN - 1));

    // Nearest demanding approach after active_dir; plain successor if none.
    always_comb begin
        idx = '0;
        cand = (active_dir == DW'(N_DIR - 1)) ? '0 : active_dir + 1'b1;
        for (int k = N_DIR - 1; k >= 1; k--) begin
            idx = DW'((int'(active_dir) + k) % N_DIR);
            if (traffic[idx]) cand = idx;
        end
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= S_GREEN;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            S_GREEN:  if (go_yellow) state_nx = S_YELLOW;
            S_YELLOW: if (timer == TW'(YELLOW_CYCLES - 1)) state_nx = S_ALLRED;
`ifdef SEMAFORO_PED_EN
            S_ALLRED: if (timer == TW'(ALLRED_CYCLES - 1)) state_nx = ped_pending ? S_WALK : S_GREEN;
            S_WALK:   if (timer == TW'(PED_CYCLES - 1)) state_nx = S_GREEN;
`else
            S_ALLRED: if (timer == TW'(ALLRED_CYCLES - 1)) state_nx = S_GREEN;
`endif
            default:  state_nx = S_GREEN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            timer      <= '0;
            active_dir <= '0;
            next_dir   <= DW'(1);
        end else begin
            timer <= (state_nx != state) ? '0 : (timer == '1) ? timer : timer + 1'b1;
            if (state == S_GREEN && state_nx == S_YELLOW) next_dir <= cand;
            if (state != S_GREEN && state_nx == S_GREEN) active_dir <= next_dir;
        end

`ifdef SEMAFORO_PED_EN
    // A request arriving on the WALK entry edge stays pending for the next rotation.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) ped_pending <= 1'b0;
        else ped_pending <= ped_req | (ped_pending & !(state_nx == S_WALK && state != S_WALK));
`else
    assign ped_pending = 1'b0;
`endif

    always_comb begin
        light = '0;
        for (int i = 0; i < N_DIR; i++)
            light[2*i +: 2] = (DW'(i) != active_dir) ? 2'b10 :
                              (state == S_GREEN) ? 2'b00 :
                              (state == S_YELLOW) ? 2'b01 : 2'b10;
`ifdef SEMAFORO_PED_EN
        ped_walk = state == S_WALK;
`endif
    end
endmodule

// File: tb/tb_semaforo_multi.sv
`timescale 1ns/1ps
// tb_semaforo_multi: directed scenarios with an expected-output queue checked every cycle.
module tb_semaforo_multi;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] traffic = '0;
    logic [7:0] light;
    logic [1:0] active_dir;
`ifdef SEMAFORO_PED_EN
    logic       ped_req = 1'b0;
    logic       ped_walk;
`endif

    typedef struct packed {
        logic [7:0] light;
        logic [1:0] dir;
        logic       walk;
    } exp_t;

    exp_t  sb[$];
    int    total = 0;
    int    bad = 0;
    string tag = "init";

    always #5 clock = ~clock;

    semaforo_multi #(
        .N_DIR(4), .GREEN_CYCLES(4), .MAX_GREEN(8),
        .YELLOW_CYCLES(2), .ALLRED_CYCLES(1), .PED_CYCLES(3)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .traffic(traffic),
`ifdef SEMAFORO_PED_EN
        .ped_req(ped_req),
        .ped_walk(ped_walk),
`endif
        .light(light),
        .active_dir(active_dir)
    );

    // ph: 0 green, 1 yellow, 2 all-red, 3 walk; dir is the approach owning the phase
    function automatic exp_t mk(int ph, int dir);
        exp_t e;
        e.light = '0;
        for (int i = 0; i < 4; i++)
            e.light[2*i +: 2] = (i == dir && ph == 0) ? 2'b00 : (i == dir && ph == 1) ? 2'b01 : 2'b10;
        e.dir = 2'(dir);
        e.walk = (ph == 3);
        return e;
    endfunction

    task automatic push(int ph, int dir, int n);
        repeat (n) sb.push_back(mk(ph, dir));
    endtask

    task automatic check_now();
        exp_t o, e;
        o.light = light;
        o.dir = active_dir;
`ifdef SEMAFORO_PED_EN
        o.walk = ped_walk;
`else
        o.walk = 1'b0;
`endif
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s: scoreboard empty, got light=%b dir=%0d", tag, o.light, o.dir);
        end else begin
            e = sb.pop_front();
            assert (o === e) else begin
                bad++;
                $error("FAIL %s: got light=%b dir=%0d walk=%b, want light=%b dir=%0d walk=%b",
                       tag, o.light, o.dir, o.walk, e.light, e.dir, e.walk);
            end
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            @(posedge clock);
            @(negedge clock);
            check_now();
        end
    endtask

    task automatic restart(logic [3:0] t);
        reset_n = 1'b0;
        #1;
        push(0, 0, 1);
        check_now();
        traffic = t;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        tag = "reset";
        repeat (2) @(negedge clock);
        push(0, 0, 1);
        check_now();
        tag = "idle";
        reset_n = 1'b1;
        push(0, 0, 50);
        drain();

        tag = "skip";
        restart(4'b0100);
        push(0, 0, 3); push(1, 0, 2); push(2, 0, 1); push(0, 2, 3);
        drain();

        tag = "maxgreen";
        restart(4'b0011);
        push(0, 0, 7); push(1, 0, 2); push(2, 0, 1);
        push(0, 1, 8); push(1, 1, 2); push(2, 1, 1); push(0, 0, 1);
        drain();

        tag = "wrap";
        restart(4'b1000);
        push(0, 0, 3); push(1, 0, 2); push(2, 0, 1); push(0, 3, 1);
        drain();
        traffic = 4'b0000;
        push(0, 3, 10);
        drain();
        traffic = 4'b0001;
        push(1, 3, 2); push(2, 3, 1); push(0, 0, 2);
        drain();

        tag = "rst_yellow";
        restart(4'b0100);
        push(0, 0, 3); push(1, 0, 1);
        drain();
        reset_n = 1'b0;
        #1;
        push(0, 0, 1);
        check_now();
        @(negedge clock);
        reset_n = 1'b1;
        push(0, 0, 3); push(1, 0, 2); push(2, 0, 1); push(0, 2, 1);
        drain();

`ifdef SEMAFORO_PED_EN
        tag = "walk";
        restart(4'b0010);
        ped_req = 1'b1;
        push(0, 0, 1);
        drain();
        ped_req = 1'b0;
        push(0, 0, 2); push(1, 0, 2); push(2, 0, 1); push(3, 0, 3); push(0, 1, 2);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
